fifo_stream_drain: RTL and testbench
====================================

# fifo_stream_drain

Downstream consumer of the synchronous FIFO. It pops bytes from the FIFO read port and presents them on a valid/ready stream, grouped into fixed-length frames with an end-of-frame marker. A 2-entry output buffer absorbs the FIFO's one-cycle read latency and sink backpressure, so the stream can sustain one beat per cycle. The block keeps a frame counter and a sticky underrun flag for status.

## Interface
- WIDTH, 8, data width; must match the FIFO's WIDTH
- FRAME_LEN, 4, beats per frame (≥1)
- CNT_WIDTH, 16, width of the completed-frame counter
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-low (0 = reset)
- en  in  1  pop enable; low stops new pops, but data already buffered or in flight still drains
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_data  in  WIDTH  FIFO read data; valid the cycle after a pop is sampled
- fifo_rd_error  in  1  FIFO read-error flag
- fifo_rd_en  out  1  pop request, combinational
- m_valid  out  1  output beat valid
- m_ready  in  1  sink ready
- m_data  out  WIDTH  output beat data
- m_last  out  1  final beat of the current frame
- frame_cnt  out  CNT_WIDTH  frames completed; wraps modulo 2^CNT_WIDTH
- underrun  out  1  sticky; set when fifo_rd_error is observed

## Operation
- FIFO read contract: a pop is sampled at edge E when fifo_rd_en=1. fifo_rd_data is valid during the cycle after E and is captured at edge E+1.
- State:
  - occ (0..2) entries held in the output buffer.
  - inflight (0..1) pops awaiting data.
  - beat (0..FRAME_LEN-1) position within the current frame.
  - frame_cnt, underrun.
- fire = m_valid && m_ready.
- fifo_rd_en = rst && en && !fifo_empty && (occ + inflight − fire < 2). It never asserts while fifo_empty=1.
- Capture: at the edge after a pop, fifo_rd_data is written into the buffer tail.
  - If fifo_rd_error=1 on that cycle, the data is discarded and underrun is set.
  - underrun stays 1 until reset.
- Output: m_valid = (occ>0). m_data is the buffer head, oldest first (strict FIFO order).
  - m_data and m_last stay stable while m_valid && !m_ready.
- Simultaneous capture and fire: head advances and the new entry is appended in the same edge. occ is unchanged.
- Framing: m_last = (beat == FRAME_LEN−1).
  - On fire, beat increments.
  - On fire with m_last, beat returns to 0 and frame_cnt increments, wrapping from all-ones to 0.
  - FRAME_LEN=1: m_last is constantly 1 whenever m_valid=1.
- en deasserted mid-frame: beat is preserved and the frame resumes when en returns. No partial-frame flush.
- Reset mid-operation:
  - Buffer and in-flight pop are discarded; occ=0, inflight=0, beat=0, frame_cnt=0, underrun=0.
  - The FIFO is reset separately by its owner.

## Timing
- Reset values: m_valid=0, m_data=0, m_last=0 (beat=0, FRAME_LEN>1), frame_cnt=0, underrun=0, fifo_rd_en=0 while rst=0.
- Latency: pop sampled at E0 → data captured at E1 → m_valid high after E1. That is one cycle from FIFO data to stream output.
- Throughput: with m_ready=1 and FIFO non-empty, one beat per cycle is sustained (occ=1, inflight=1 steady state).
- Backpressure: with m_ready=0, at most 2 entries are held. Pops stop once occ + inflight = 2.
- fifo_rd_en depends combinationally on m_ready, occ, inflight and fifo_empty. There are no other combinational paths.

## Structure
- Shared include fifo_defs.vh holds:
  - default WIDTH=8 and DEPTH/PTR_WIDTH, shared with the FIFO;
  - FIFO_RD_LAT=1 constant.
- Sub-module stream_buf2 implements the 2-entry register buffer:
  - inputs: push, push_data, pop;
  - outputs: occ, head data.
- The top level contains the credit logic, in-flight flag, beat counter, frame counter and underrun flag.

## Test plan
- **Reset:** hold rst=0 for 2 cycles with FIFO non-empty → fifo_rd_en=0 and all outputs at reset values; first pop in the first cycle after rst=1.
- **Streaming:** write 16 bytes 0,2,…,30 into the FIFO, m_ready=1, FRAME_LEN=4 → 16 consecutive beats in order 0..30; m_last on 6,14,22,30; frame_cnt=4; no bubbles after the first beat.
- **Backpressure:** m_ready=0 for 10 cycles with 8 bytes queued → exactly 2 pops issued; m_data holds the first byte; no loss or reorder after m_ready=1.
- **Empty boundary:** FIFO holds 5 bytes → 5 beats; fifo_rd_en never high with fifo_empty=1; underrun=0; beat=1, frame_cnt=1.
- **Enable gating:** en=0 after 2 beats of a frame → outstanding data drains, then no pops; en=1 → frame resumes with m_last on the 4th beat overall.
- **Error/reset:** force fifo_rd_error=1 on a capture cycle → that byte is dropped and underrun=1 until reset; assert rst=0 mid-frame → occ, beat, frame_cnt and underrun cleared on the next edge.

Source files
------------

// File: rtl/fifo_stream_drain_pkg.sv
// Shared definitions for the FIFO stream drain: data width default, FIFO read
// latency and the output buffer occupancy encoding.
package fifo_stream_drain_pkg;

    // Default data width, shared with the upstream synchronous FIFO.
    localparam int unsigned DefWidth = 8;

    // Cycles from a sampled pop to the edge that captures fifo_rd_data.
    localparam int unsigned FifoRdLat = 1;

    // Output buffer depth: one entry per cycle of read latency plus one for the head.
    localparam int unsigned BufDepth = FifoRdLat + 1;

    // Occupancy of the 2-entry output buffer.
    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_e;

    // Width of the beat-within-frame counter; at least one bit.
    function automatic int unsigned beat_width(int unsigned frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_drain_if.sv
// FIFO read port and valid/ready output stream of the drain, bundled.
// master: the drain itself; slave: the FIFO plus the stream sink.
interface fifo_stream_drain_if
    import fifo_stream_drain_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
);

    // FIFO read side
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_error;
    logic             fifo_rd_en;

    // Output stream side
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  fifo_rd_error,
        output fifo_rd_en,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output fifo_rd_error,
        input  fifo_rd_en,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/fifo_stream_drain_stream_buf2.sv
// Two-entry register buffer (stream_buf2). Entry 0 is always the head; a pop
// shifts entry 1 down. Push and pop in the same cycle keep occupancy unchanged.
module fifo_stream_drain_stream_buf2
    import fifo_stream_drain_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output occ_e             occ_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    occ_e             occ_q;
    occ_e             occ_d;

    // Next-state: append at the tail, shift on pop; caller never pops empty or pushes full.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        occ_d    = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == OccEmpty) begin
                    mem_d[0] = push_data_i;
                    occ_d    = OccOne;
                end else if (occ_q == OccOne) begin
                    mem_d[1] = push_data_i;
                    occ_d    = OccFull;
                end
            end
            2'b01: begin
                mem_d[0] = mem_q[1];
                if (occ_q == OccFull) begin
                    occ_d = OccOne;
                end else if (occ_q == OccOne) begin
                    occ_d = OccEmpty;
                end
            end
            2'b11: begin
                if (occ_q == OccFull) begin
                    mem_d[0] = mem_q[1];
                    mem_d[1] = push_data_i;
                end else begin
                    mem_d[0] = push_data_i;
                    occ_d    = OccOne;
                end
            end
            default: begin
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            occ_q    <= OccEmpty;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            occ_q    <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[0];

endmodule

// File: rtl/fifo_stream_drain.sv
// Pops bytes from a synchronous FIFO and presents them as a framed valid/ready
// stream. Credits (buffer entries + in-flight pop - this cycle's fire) limit
// pops so the 2-entry buffer never overflows; frame counter and sticky
// underrun flag report status.
module fifo_stream_drain
    import fifo_stream_drain_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    fifo_stream_drain_if.master  bus,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic                 underrun
);

    localparam int unsigned BeatW = beat_width(FRAME_LEN);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(FRAME_LEN - 1);

    occ_e             occ;
    logic [WIDTH-1:0] head;
    logic             m_valid;
    logic             m_last;
    logic             fire;
    logic             push;
    logic             rd_en;
    logic [2:0]       credit_used;

    logic                 inflight_q;
    logic                 inflight_d;
    logic [BeatW-1:0]     beat_q;
    logic [BeatW-1:0]     beat_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q;
    logic [CNT_WIDTH-1:0] frame_cnt_d;
    logic                 underrun_q;
    logic                 underrun_d;

    fifo_stream_drain_stream_buf2 #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (bus.fifo_rd_data),
        .pop_i       (fire),
        .occ_o       (occ),
        .head_o      (head)
    );

    // Handshake, credit check and capture decode.
    always_comb begin
        m_valid     = (occ != OccEmpty);
        m_last      = (beat_q == LastBeat);
        fire        = m_valid && bus.m_ready;
        // A fire this cycle frees an entry at the same edge the popped data lands.
        credit_used = 3'(occ) + 3'(inflight_q);
        rd_en       = rst && en && !bus.fifo_empty
                      && (credit_used < (3'(BufDepth) + 3'(fire)));
        // Errored reads are dropped rather than written into the buffer.
        push        = inflight_q && !bus.fifo_rd_error;
        inflight_d  = rd_en;
        underrun_d  = underrun_q || (inflight_q && bus.fifo_rd_error);
    end

    // Beat position and completed-frame count advance on each accepted beat.
    always_comb begin
        beat_d      = beat_q;
        frame_cnt_d = frame_cnt_q;
        if (fire) begin
            if (m_last) begin
                beat_d      = '0;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    // Status and in-flight registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight_q  <= 1'b0;
            beat_q      <= '0;
            frame_cnt_q <= '0;
            underrun_q  <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            beat_q      <= beat_d;
            frame_cnt_q <= frame_cnt_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = head;
    assign bus.m_last     = m_last;
    assign frame_cnt      = frame_cnt_q;
    assign underrun       = underrun_q;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural FIFO with one-cycle read latency,
// scoreboard of expected bytes, table of streaming scenarios and hand-written
// backpressure, enable, error and reset sequences.
module tb_fifo_stream_drain;

    localparam int unsigned W  = 8;
    localparam int unsigned FL = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [CW-1:0] frame_cnt;
    logic          underrun;

    fifo_stream_drain_if #(.WIDTH(W)) bus ();

    fifo_stream_drain #(
        .WIDTH     (W),
        .FRAME_LEN (FL),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .bus       (bus),
        .frame_cnt (frame_cnt),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       do_reset;
        int       n;
        logic [7:0] base;
        logic [7:0] stride;
        bit       rand_ready;
        int       exp_frames;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] fifo_m [$];
    logic [7:0] exp_q  [$];
    int  checks = 0;
    int  errors = 0;
    int  exp_beat = 0;
    int  exp_frames = 0;
    bit  exp_under = 0;
    bit  tb_inflight = 0;
    int  cyc = 0;
    int  fires = 0;
    int  pops = 0;
    int  viol = 0;
    int  first_fire = -1;
    int  last_fire = -1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_byte(logic [7:0] v);
        fifo_m.push_back(v);
        exp_q.push_back(v);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic drop(logic [7:0] v);
        bit found = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (!found && exp_q[i] == v) begin
                exp_q.delete(i);
                found = 1;
            end
        end
        if (!found) check("drop_target", 32'(v), 32'hFFFF);
    endtask

    // One clock: sample at negedge, update FIFO model just after posedge.
    task automatic tick();
        logic       pop_now;
        logic [7:0] d;
        @(negedge clk);
        cyc++;
        pop_now = bus.fifo_rd_en;
        if (bus.fifo_rd_en && bus.fifo_empty) viol++;
        if (rst) begin
            if (tb_inflight && bus.fifo_rd_error) begin
                drop(bus.fifo_rd_data);
                exp_under = 1;
            end
            if (bus.m_valid && bus.m_ready) begin
                fires++;
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    d = exp_q.pop_front();
                    check("m_data", 32'(bus.m_data), 32'(d));
                    check("m_last", 32'(bus.m_last), 32'(exp_beat == FL - 1));
                    if (exp_beat == FL - 1) begin
                        exp_beat = 0;
                        exp_frames++;
                    end else begin
                        exp_beat++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        tb_inflight = pop_now;
        if (pop_now) begin
            if (fifo_m.size() > 0) bus.fifo_rd_data = fifo_m.pop_front();
            pops++;
        end
        bus.fifo_empty = (fifo_m.size() == 0);
    endtask

    task automatic start_reset();
        rst = 1'b0;
        fifo_m.delete();
        exp_q.delete();
        exp_beat    = 0;
        exp_frames  = 0;
        exp_under   = 0;
        tb_inflight = 0;
        bus.fifo_empty = 1'b1;
    endtask

    task automatic drain(int budget, bit rand_ready);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 0);
        bus.m_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int p;
        rst               = 1'b0;
        en                = 1'b1;
        bus.m_ready       = 1'b1;
        bus.fifo_rd_error = 1'b0;
        bus.fifo_rd_data  = '0;
        bus.fifo_empty    = 1'b1;

        vecs[0] = '{do_reset: 1, n: 16, base: 8'h00, stride: 8'h02, rand_ready: 0, exp_frames: 4};
        vecs[1] = '{do_reset: 0, n: 5,  base: 8'h40, stride: 8'h01, rand_ready: 0, exp_frames: 5};
        vecs[2] = '{do_reset: 0, n: 3,  base: 8'h48, stride: 8'h01, rand_ready: 0, exp_frames: 6};
        vecs[3] = '{do_reset: 1, n: 12, base: 8'h80, stride: 8'h03, rand_ready: 1, exp_frames: 3};

        // Reset with FIFO non-empty: no pops, outputs at reset values.
        start_reset();
        for (int i = 0; i < 4; i++) push_byte(8'(8'h10 + i));
        tick();
        tick();
        check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        check("rst_m_valid", 32'(bus.m_valid), 0);
        check("rst_m_data", 32'(bus.m_data), 0);
        check("rst_m_last", 32'(bus.m_last), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_underrun", 32'(underrun), 0);
        rst = 1'b1;
        #1;
        check("first_pop", 32'(bus.fifo_rd_en), 1);
        drain(50, 0);
        check("rst_test_frames", 32'(frame_cnt), 1);

        // Table-driven streaming scenarios.
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].do_reset) begin
                start_reset();
                tick();
                rst = 1'b1;
            end
            first_fire = -1;
            viol       = 0;
            for (int k = 0; k < vecs[i].n; k++) begin
                push_byte(8'(vecs[i].base + 8'(k) * vecs[i].stride));
            end
            drain(300, vecs[i].rand_ready);
            check("vec_frame_cnt", 32'(frame_cnt), 32'(vecs[i].exp_frames));
            check("vec_underrun", 32'(underrun), 0);
            check("vec_rd_en_empty", 32'(viol), 0);
            if (!vecs[i].rand_ready) begin
                check("vec_no_bubble", 32'(last_fire - first_fire), 32'(vecs[i].n - 1));
            end
        end

        // Backpressure: only two pops while the sink stalls.
        start_reset();
        tick();
        rst = 1'b1;
        bus.m_ready = 1'b0;
        pops = 0;
        for (int i = 0; i < 8; i++) push_byte(8'(8'h50 + i));
        for (int i = 0; i < 10; i++) begin
            bus.m_ready = 1'b0;
            tick();
        end
        check("bp_pops", 32'(pops), 2);
        check("bp_m_valid", 32'(bus.m_valid), 1);
        check("bp_m_data", 32'(bus.m_data), 32'h50);
        drain(100, 0);
        check("bp_frame_cnt", 32'(frame_cnt), 2);

        // Enable gating mid-frame: in-flight data drains, beat is preserved.
        start_reset();
        tick();
        rst = 1'b1;
        fires = 0;
        for (int i = 0; i < 8; i++) push_byte(8'(8'h60 + i));
        n = 0;
        while (fires < 1 && n < 50) begin
            tick();
            n++;
        end
        check("en_first_beat", 32'(fires), 1);
        en = 1'b0;
        repeat (6) tick();
        check("en_drained_beats", 32'(fires), 3);
        check("en_idle_valid", 32'(bus.m_valid), 0);
        p = pops;
        repeat (5) tick();
        check("en_no_pops", 32'(pops), 32'(p));
        check("en_rd_en", 32'(bus.fifo_rd_en), 0);
        check("en_frame_cnt", 32'(frame_cnt), 0);
        en = 1'b1;
        drain(100, 0);
        check("en_resume_frames", 32'(frame_cnt), 2);

        // Read error on the capture of 0xA2: byte dropped, underrun sticky.
        start_reset();
        tick();
        rst = 1'b1;
        fires = 0;
        for (int i = 0; i < 6; i++) push_byte(8'(8'hA0 + i));
        n = 0;
        while (!(tb_inflight && bus.fifo_rd_data == 8'hA2) && n < 50) begin
            tick();
            n++;
        end
        check("err_reach_capture", 32'(n < 50), 1);
        bus.fifo_rd_error = 1'b1;
        tick();
        bus.fifo_rd_error = 1'b0;
        drain(100, 0);
        check("err_underrun", 32'(underrun), 32'(exp_under));
        check("err_beats", 32'(fires), 5);
        check("err_frame_cnt", 32'(frame_cnt), 1);
        repeat (5) tick();
        check("err_underrun_sticky", 32'(underrun), 1);

        // Reset mid-frame with a full buffer clears everything on the next edge.
        push_byte(8'hB0);
        push_byte(8'hB1);
        drain(50, 0);
        for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i));
        for (int i = 0; i < 4; i++) begin
            bus.m_ready = 1'b0;
            tick();
        end
        check("pre_rst_last", 32'(bus.m_last), 1);
        check("pre_rst_frames", 32'(frame_cnt), 1);
        start_reset();
        tick();
        check("mid_rst_valid", 32'(bus.m_valid), 0);
        check("mid_rst_last", 32'(bus.m_last), 0);
        check("mid_rst_frames", 32'(frame_cnt), 0);
        check("mid_rst_underrun", 32'(underrun), 0);
        check("mid_rst_rd_en", 32'(bus.fifo_rd_en), 0);
        rst = 1'b1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'(8'hD0 + i));
        drain(50, 0);
        check("post_rst_frames", 32'(frame_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
